// File: rtl/calc_pkg.sv
// Shared types and sizing helpers for the sequential calculator core.
package calc_pkg;

    // Operation codes presented on the op input.
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_PASS = 3'd7
    } op_t;

    // Control FSM states of the core.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the core supports; sizes the iteration counter for that case.
    localparam int MAX_WIDTH  = 16;
    localparam int ITER_CNT_W = $clog2(MAX_WIDTH + 1);

    // Iteration counter width for a given operand width.
    function automatic int iter_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Shared WIDTH-iteration engine: shift-add multiply and restoring divide.
// A start pulse loads the operands; done is asserted during the last
// iteration, with res_hi/res_lo presenting that iteration's outcome so the
// caller can register the final value on the same edge.
module seq_muldiv_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = iter_cnt_width(WIDTH);

    logic             busy_reg;
    logic             is_div_reg;
    logic [CW-1:0]    cnt_reg;
    // MUL: hi = partial product, lo = multiplier shifting out / product low.
    // DIV: hi = partial remainder, lo = dividend shifting out / quotient in.
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opnd_reg;   // multiplicand (MUL) or divisor (DIV)

    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // One iteration of either algorithm, computed from the current registers.
    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        add_sum = '0;
        shifted = '0;
        diff    = '0;
        if (is_div_reg) begin
            shifted = {hi_reg, lo_reg[WIDTH-1]};
            diff    = shifted - {1'b0, opnd_reg};
            if (shifted >= {1'b0, opnd_reg}) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
            hi_next = add_sum[WIDTH:1];
            lo_next = {add_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    assign done   = busy_reg && (cnt_reg == CW'(WIDTH - 1));
    assign res_hi = hi_next;
    assign res_lo = lo_next;

    // Operand load on start, then WIDTH iterations while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg   <= 1'b0;
            is_div_reg <= 1'b0;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opnd_reg   <= '0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            is_div_reg <= is_div;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= is_div ? opa : opb;
            opnd_reg   <= is_div ? opb : opa;
        end else if (busy_reg) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_calc_core.sv
// Sequential calculator core: valid/ready request and result handshakes,
// single-cycle ALU ops, multi-cycle MUL/DIV and a chaining accumulator.
module seq_calc_core
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic               use_acc,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               div_zero
);

    state_t             state_reg, state_next;
    logic [2*WIDTH-1:0] result_reg, result_next;
    logic               carry_reg, carry_next;
    logic               zero_reg, zero_next;
    logic               div_zero_reg, div_zero_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;

    logic [WIDTH-1:0]   eff_a;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               md_start;
    logic               md_is_div;
    logic               md_done;
    logic [WIDTH-1:0]   md_hi;
    logic [WIDTH-1:0]   md_lo;

    assign eff_a = use_acc ? acc_reg : a;
    assign sum   = {1'b0, eff_a} + {1'b0, b};
    assign diff  = {1'b0, eff_a} - {1'b0, b};

    seq_muldiv_unit #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (md_is_div),
        .opa    (eff_a),
        .opb    (b),
        .done   (md_done),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    // Next-state, datapath selection and accumulator update.
    always_comb begin
        state_next    = state_reg;
        result_next   = result_reg;
        carry_next    = carry_reg;
        zero_next     = zero_reg;
        div_zero_next = div_zero_reg;
        acc_next      = acc_reg;
        md_start      = 1'b0;
        md_is_div     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    carry_next    = 1'b0;
                    div_zero_next = 1'b0;
                    state_next    = DONE;
                    unique case (op_t'(op))
                        OP_ADD: begin
                            result_next = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                            carry_next  = sum[WIDTH];
                        end
                        OP_SUB: begin
                            // The borrow out of the widened subtract is exactly A < B.
                            result_next = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                            carry_next  = diff[WIDTH];
                        end
                        OP_MUL: begin
                            md_start   = 1'b1;
                            state_next = CALC;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                result_next   = {eff_a, {WIDTH{1'b1}}};
                                div_zero_next = 1'b1;
                            end else begin
                                md_start   = 1'b1;
                                md_is_div  = 1'b1;
                                state_next = CALC;
                            end
                        end
                        OP_AND:  result_next = {{WIDTH{1'b0}}, eff_a & b};
                        OP_OR:   result_next = {{WIDTH{1'b0}}, eff_a | b};
                        OP_XOR:  result_next = {{WIDTH{1'b0}}, eff_a ^ b};
                        OP_PASS: result_next = {{WIDTH{1'b0}}, b};
                        default: result_next = {{WIDTH{1'b0}}, b};
                    endcase
                end
            end
            CALC: begin
                if (md_done) begin
                    result_next   = {md_hi, md_lo};
                    carry_next    = 1'b0;
                    div_zero_next = 1'b0;
                    state_next    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_next   = result_reg[WIDTH-1:0];
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // The zero flag is formed only when a new result is loaded, so it stays
        // stable with the result while the consumer stalls.
        if (state_next == DONE && state_reg != DONE) begin
            zero_next = (result_next == '0);
        end
    end

    // State, result/flag and accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            result_reg   <= '0;
            carry_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            acc_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            result_reg   <= result_next;
            carry_reg    <= carry_next;
            zero_reg     <= zero_next;
            div_zero_reg <= div_zero_next;
            acc_reg      <= acc_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign carry     = carry_reg;
    assign zero      = zero_reg;
    assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_seq_calc_core.sv
// Directed self-checking bench for seq_calc_core (WIDTH=8).
module tb_seq_calc_core;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     op = '0;
    logic           use_acc = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic           carry;
    logic           zero;
    logic           div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    // Bench model state
    logic [2*W-1:0] exp_res = '0;
    logic           exp_c   = 1'b0;
    logic           exp_z   = 1'b0;
    logic           exp_dz  = 1'b0;
    logic           pending = 1'b0;
    logic           m_busy  = 1'b0;
    logic [W-1:0]   m_acc   = '0;

    seq_calc_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .use_acc   (use_acc),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    endtask

    // Arithmetic definition of every operation, plus its latency in cycles.
    function automatic void model(input int o, input int ea, input int eb,
                                  output logic [2*W-1:0] r, output logic c,
                                  output logic z, output logic dz, output int lat);
        int v;
        c = 1'b0; dz = 1'b0; lat = 1; v = 0;
        case (o)
            0: begin v = ea + eb; c = (v >= M); v = v % M; end
            1: begin v = (ea - eb + M) % M; c = (ea < eb); end
            2: begin v = ea * eb; lat = W + 1; end
            3: begin
                if (eb == 0) begin v = ea * M + (M - 1); dz = 1'b1; end
                else begin v = (ea % eb) * M + (ea / eb); lat = W + 1; end
            end
            4: v = ea & eb;
            5: v = ea | eb;
            6: v = ea ^ eb;
            default: v = eb;
        endcase
        r = (2*W)'(v);
        z = (v == 0);
    endfunction

    // Every cycle: in_ready must reflect the model's busy state; any valid
    // result must match the model and stay stable while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            if (out_valid) begin
                if (pending) begin
                    check("result", {16'd0, result}, {16'd0, exp_res});
                    check("carry", {31'd0, carry}, {31'd0, exp_c});
                    check("zero", {31'd0, zero}, {31'd0, exp_z});
                    check("div_zero", {31'd0, div_zero}, {31'd0, exp_dz});
                end else begin
                    check("spurious_valid", {31'd0, out_valid}, 32'd0);
                end
            end
        end
    end

    // Issue one request, check its latency, stall the result, then retire it.
    task automatic run_op(input logic [2:0] o, input logic ua, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input int stall, input int lit);
        int lat;
        int k;
        logic [W-1:0] ea;
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        op = o; use_acc = ua; a = aa; b = bb; in_valid = 1'b1;
        ea = ua ? m_acc : aa;
        model(int'(o), int'(ea), int'(bb), exp_res, exp_c, exp_z, exp_dz, lat);
        @(posedge clk);
        #1 in_valid = 1'b0;
        m_busy = 1'b1;
        pending = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < lat + 3);
        check("latency", k, lat);
        if (lit >= 0) check("literal", {16'd0, result}, lit);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        m_busy = 1'b0;
        pending = 1'b0;
        m_acc = exp_res[W-1:0];
        @(negedge clk);
        check("idle_after", {31'd0, out_valid}, 32'd0);
        $display("op=%0d use_acc=%0b a=%0d b=%0d -> result=0x%04h carry=%0b zero=%0b div_zero=%0b latency=%0d",
                 o, ua, aa, bb, exp_res, exp_c, exp_z, exp_dz, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);

        run_op(3'd0, 1'b0, 8'd200, 8'd100, 0, 16'h002C);   // ADD with carry
        run_op(3'd2, 1'b0, 8'd15,  8'd13,  0, 16'h00C3);   // MUL
        run_op(3'd3, 1'b0, 8'd100, 8'd7,   0, 16'h020E);   // DIV
        run_op(3'd3, 1'b0, 8'h2A,  8'd0,   0, 16'h2AFF);   // DIV by zero
        run_op(3'd1, 1'b0, 8'd3,   8'd5,   5, 16'h00FE);   // SUB borrow, stalled
        run_op(3'd7, 1'b0, 8'd0,   8'd10,  0, 16'h000A);   // PASS loads acc
        run_op(3'd0, 1'b1, 8'd0,   8'd5,   0, 16'h000F);   // acc + 5
        run_op(3'd2, 1'b1, 8'd0,   8'd3,   0, 16'h002D);   // acc * 3
        run_op(3'd0, 1'b0, 8'd128, 8'd128, 1, 16'h0000);   // zero with carry
        run_op(3'd2, 1'b0, 8'd255, 8'd255, 0, 16'hFE01);   // max product
        run_op(3'd3, 1'b0, 8'd255, 8'd1,   0, 16'h00FF);   // divide by one
        run_op(3'd3, 1'b0, 8'd5,   8'd9,   0, 16'h0500);   // dividend < divisor
        run_op(3'd4, 1'b0, 8'hF0,  8'h3C,  0, 16'h0030);
        run_op(3'd5, 1'b0, 8'hF0,  8'h3C,  0, 16'h00FC);
        run_op(3'd6, 1'b0, 8'hF0,  8'h3C,  2, 16'h00CC);

        // Reset in the middle of a MUL aborts it and clears the accumulator.
        op = 3'd2; use_acc = 1'b0; a = 8'd15; b = 8'd13; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        m_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_busy = 1'b0;
        m_acc = '0;
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        $display("reset mid-MUL -> out_valid=%0b in_ready=%0b", out_valid, in_ready);
        run_op(3'd0, 1'b1, 8'd99, 8'd0, 0, 16'h0000);      // acc cleared to 0
        run_op(3'd0, 1'b0, 8'd1,  8'd1, 0, 16'h0002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
